// File: rtl/switch_debouncer.sv
// Switch debouncer: 2-flop synchronizers, shared sample-tick prescaler, per-bit
// stability counters, edge pulses and a valid/ready change-event register.

module switch_debounce_lane #(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 3
) (
    input  logic board_clk,
    input  logic board_rst_n,
    input  logic tick,
    input  logic level,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic update
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_TICKS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_W'(1);
    assign update  = (level != stable) && tick && (cnt_inc == LIMIT);

    // The counter tops out at LIMIT-1; reaching LIMIT is the accept, so it never wraps.
    always_ff @(posedge board_clk or negedge board_rst_n) begin
        if (!board_rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= update & level;
            fall <= update & ~level;
            if (level == stable) begin
                cnt <= '0;
            end else if (tick) begin
                if (update) begin
                    stable <= level;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end
endmodule

module switch_debouncer #(
    parameter int WIDTH        = 4,
    parameter int TICK_BITS    = 12,
    parameter int STABLE_TICKS = 4
) (
    input  logic             board_clk,
    input  logic             board_rst_n,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic [WIDTH-1:0] evt_state
);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    logic [WIDTH-1:0]     sync_q1;
    logic [WIDTH-1:0]     sync_q2;
    logic [TICK_BITS-1:0] presc;
    logic                 tick;
    logic [WIDTH-1:0]     chg;

    always_ff @(posedge board_clk or negedge board_rst_n) begin
        if (!board_rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            presc   <= '0;
        end else begin
            sync_q1 <= switches;
            sync_q2 <= sync_q1;
            presc   <= presc + TICK_BITS'(1);
        end
    end

    assign tick = &presc;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            switch_debounce_lane #(
                .STABLE_TICKS(STABLE_TICKS),
                .CNT_W       (CNT_W)
            ) u_lane (
                .board_clk  (board_clk),
                .board_rst_n(board_rst_n),
                .tick       (tick),
                .level      (sync_q2[i]),
                .stable     (sw_stable[i]),
                .rise       (sw_rise[i]),
                .fall       (sw_fall[i]),
                .update     (chg[i])
            );
        end
    endgenerate

    // A handshake in the same cycle as fresh changes re-arms with only the fresh bits.
    always_ff @(posedge board_clk or negedge board_rst_n) begin
        if (!board_rst_n) begin
            evt_valid <= 1'b0;
            evt_mask  <= '0;
        end else if (!evt_valid) begin
            if (chg != '0) begin
                evt_valid <= 1'b1;
                evt_mask  <= chg;
            end
        end else if (evt_ready) begin
            if (chg != '0) begin
                evt_mask <= chg;
            end else begin
                evt_valid <= 1'b0;
                evt_mask  <= '0;
            end
        end else begin
            evt_mask <= evt_mask | chg;
        end
    end

    assign evt_state = sw_stable;
endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 4: number of switch inputs.
REQ-002 Parameter TICK_BITS, default 12: prescaler width; one sample tick every 2^TICK_BITS clocks.
REQ-003 Parameter STABLE_TICKS, default 4: consecutive ticks a new level must persist to be accepted; legal range 1..255.
REQ-004 board_clk  in  1  single clock; all logic on rising edge.
REQ-005 board_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 switches  in  WIDTH  raw asynchronous switch levels.
REQ-007 sw_stable  out  WIDTH  debounced switch levels.
REQ-008 sw_rise  out  WIDTH  one-cycle pulse per bit on debounced 0->1.
REQ-009 sw_fall  out  WIDTH  one-cycle pulse per bit on debounced 1->0.
REQ-010 evt_valid  out  1  change event pending.
REQ-011 evt_ready  in  1  consumer accepts the event when high with evt_valid.
REQ-012 evt_mask  out  WIDTH  bits that changed since the last accepted event.
REQ-013 evt_state  out  WIDTH  current debounced levels accompanying the event.

Function
REQ-014 Each switch bit passes through a 2-flop synchronizer before any other use.
REQ-015 Free-running TICK_BITS prescaler counts up from 0, wraps; tick is high for one cycle when the prescaler is all ones.
REQ-016 Per bit: when synced level equals sw_stable, the bit's counter clears to 0 that cycle, regardless of tick.
REQ-017 Per bit: when synced level differs from sw_stable and tick is high, the counter increments; if the incremented value equals STABLE_TICKS, sw_stable takes the synced level and the counter clears.
REQ-018 Counter width is the minimum needed to hold STABLE_TICKS; it never wraps.
REQ-019 sw_rise/sw_fall assert for exactly the one cycle in which sw_stable first shows the new level; never both for the same bit.
REQ-020 Bits are independent; several bits may update in the same cycle and all pulse together.
REQ-021 Change vector chg = bits updating this cycle. If evt_valid=0 and chg!=0: evt_valid<=1, evt_mask<=chg.
REQ-022 If evt_valid=1, no handshake, chg!=0: evt_mask<=evt_mask|chg; evt_valid stays 1.
REQ-023 Handshake (evt_valid & evt_ready) with chg=0: evt_valid<=0, evt_mask<=0 next cycle.
REQ-024 Handshake with chg!=0 in same cycle: evt_valid stays 1, evt_mask<=chg (new changes never lost).
REQ-025 evt_state always equals sw_stable; evt_mask/evt_state stable while evt_valid=1 and no new chg.
REQ-026 evt_ready while evt_valid=0 has no effect.
REQ-027 Latency: switch edge to sw_stable update is 2 sync cycles plus STABLE_TICKS ticks (first tick may be partial).

Reset
REQ-028 On board_rst_n low: synchronizers, prescaler, per-bit counters, sw_stable, sw_rise, sw_fall, evt_valid, evt_mask, evt_state all 0, immediately and asynchronously.
REQ-029 Reset mid-count discards partial counts; after release debouncing restarts from prescaler 0.
REQ-030 A switch held high through reset release is debounced normally and produces a rise pulse and event.

Verification (TICK_BITS=2, STABLE_TICKS=3)
REQ-031 Reset asserted, switches=4'b1111 -> all outputs 0 while reset low.
REQ-032 switches 0000->0001 held -> sw_stable=0001 within 2+12 cycles, sw_rise=0001 one cycle, evt_valid=1, evt_mask=0001, evt_state=0001.
REQ-033 bit1 high for 2 ticks then low -> sw_stable, sw_rise, evt_valid unchanged.
REQ-034 evt_ready=0; stable 0001; bit0 falls, later bit2 rises -> one event, evt_mask=0101, evt_state=0100, sw_fall[0] and sw_rise[2] each pulse once.
REQ-035 evt_ready=1 in the cycle bit3 updates -> evt_valid stays 1, evt_mask=1000 next cycle.
REQ-036 Reset pulse with bit0 counter at 2 -> counter and outputs 0; after release bit0 needs full 3 ticks again.
